// File: rtl/flow_pkg.sv
// Shared constants and types for the register file / program counter datapath.
package flow_pkg;

  // Register index that holds the program counter.
  localparam int unsigned REG_PC = 0;

  localparam int unsigned DEFAULT_WIDTH    = 16;
  localparam int unsigned DEFAULT_NUM_REGS = 16;

  typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/pc_next.sv
// Program counter next-state selector.
// Priority: write-back to PC > branch load > increment > hold.
module pc_next #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PC_STEP = 1
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_inc,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_target,
  input  logic             wr_pc,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] pc_nxt
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  // Priority-resolved PC next state; the increment wraps modulo 2^WIDTH.
  always_comb begin
    pc_nxt = pc;
    if (wr_pc) begin
      pc_nxt = wr_data;
    end else if (pc_load) begin
      pc_nxt = pc_target;
    end else if (pc_inc) begin
      pc_nxt = pc + STEP;
    end
  end

endmodule

// File: rtl/regfile_pc.sv
// Register file with the program counter held in register 0.
// Optional build macro: REGFILE_BYPASS_EN -- read ports return the next-state value of the
// addressed register instead of the stored value.
module regfile_pc
  import flow_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned     NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned     RD_PORTS = 2,
  parameter int unsigned     PC_STEP  = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int unsigned    AW       = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pc_inc,
  input  logic                         pc_load,
  input  logic [WIDTH-1:0]             pc_target,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [RD_PORTS*AW-1:0]       rd_addr,
  output logic [RD_PORTS*WIDTH-1:0]    rd_data,
  output logic [WIDTH-1:0]             pc,
  output logic [NUM_REGS*WIDTH-1:0]    registers,
  output logic                         pc_conflict
);

  logic             wr_pc;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_nxt;
  logic             conflict_q;

  // Next-state view of every register, feeding the bypass read path.
  logic [NUM_REGS*WIDTH-1:0] next_view;

  assign wr_pc = wr_en && (wr_addr == AW'(REG_PC));

  pc_next #(
    .WIDTH  (WIDTH),
    .PC_STEP(PC_STEP)
  ) u_pc_next (
    .pc       (pc_q),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .wr_pc    (wr_pc),
    .wr_data  (wr_data),
    .pc_nxt   (pc_nxt)
  );

  // PC register; reset discards any pending write, load or increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  // Flag a write-back to PC that collided with a branch load (write-back already won).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= wr_pc && pc_load;
    end
  end

  assign pc          = pc_q;
  assign pc_conflict = conflict_q;

  assign registers[REG_PC*WIDTH +: WIDTH] = pc_q;
  assign next_view[REG_PC*WIDTH +: WIDTH] = pc_nxt;

  // General-purpose registers 1..NUM_REGS-1.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_gp
    logic             hit;
    logic [WIDTH-1:0] q;

    assign hit = wr_en && (wr_addr == AW'(gi));

    // Write-back storage for one general-purpose register.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        q <= '0;
      end else if (hit) begin
        q <= wr_data;
      end
    end

    assign registers[gi*WIDTH +: WIDTH] = q;
    assign next_view[gi*WIDTH +: WIDTH] = hit ? wr_data : q;
  end

  // Combinational read ports.
  for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[gp*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[gp*WIDTH +: WIDTH] = next_view[addr*WIDTH +: WIDTH];
`else
    assign rd_data[gp*WIDTH +: WIDTH] = registers[addr*WIDTH +: WIDTH];
`endif
  end

`ifndef REGFILE_BYPASS_EN
  // Next-state view only feeds the bypass path.
  logic unused_next_view;
  assign unused_next_view = ^next_view;
`endif

endmodule

// File: tb/tb_regfile_pc.sv
// Self-checking bench for regfile_pc with a behavioural model and directed vectors.
module tb_regfile_pc;

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 16;
  localparam int unsigned RP = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned STEP = 1;
  localparam logic [15:0] RST_PC = 16'h0100;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pc_inc = 1'b0;
  logic              pc_load = 1'b0;
  logic [W-1:0]      pc_target = '0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic [RP*AW-1:0]  rd_addr = '0;
  logic [RP*W-1:0]   rd_data;
  logic [W-1:0]      pc;
  logic [NR*W-1:0]   registers;
  logic              pc_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_pc #(
    .WIDTH   (W),
    .NUM_REGS(NR),
    .RD_PORTS(RP),
    .PC_STEP (STEP),
    .RESET_PC(RST_PC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pc         (pc),
    .registers  (registers),
    .pc_conflict(pc_conflict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [NR];
  logic        m_conf;

  function automatic logic [15:0] want_pc();
    if (wr_en && wr_addr == 0) return wr_data;
    if (pc_load) return pc_target;
    if (pc_inc) return 16'(m_regs[0] + STEP);
    return m_regs[0];
  endfunction

  function automatic logic [15:0] want_rd(input int a);
`ifdef REGFILE_BYPASS_EN
    if (a == 0) return want_pc();
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
      m_regs[0] = RST_PC;
      m_conf = 1'b0;
    end else begin
      m_conf = wr_en && wr_addr == 0 && pc_load;
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      m_regs[0] = want_pc();
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    logic [NR*W-1:0] flat;
    for (int i = 0; i < NR; i++) flat[i*W +: W] = m_regs[i];
    chk("pc", 256'(pc), 256'(m_regs[0]));
    chk("registers", 256'(registers), 256'(flat));
    chk("pc_conflict", 256'(pc_conflict), 256'(m_conf));
    if (!reset) begin
      for (int p = 0; p < RP; p++) begin
        chk($sformatf("rd_data%0d", p), 256'(rd_data[p*W +: W]),
            256'(want_rd(int'(rd_addr[p*AW +: AW]))));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pc_inc = 0; pc_load = 0; wr_en = 0;
  endtask

  function automatic logic [15:0] reg_of(input int i);
    return registers[i*W +: W];
  endfunction

  initial begin
    rd_addr = {4'd0, 4'd0, 4'd0};
    cyc();
    cyc();
    reset = 0;
    #1;
    chk("reset_pc", 256'(pc), 256'(16'h0100));
    chk("reset_regs", 256'(registers >> W), 256'(0));
    chk("reset_conflict", 256'(pc_conflict), 256'(0));

    // Wrap: load PC to 0xFFFE via write-back, then increment three times.
    cyc();
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFE;
    cyc();
    idle();
    chk("wb_pc", 256'(pc), 256'(16'hFFFE));
    pc_inc = 1;
    cyc(); chk("inc1", 256'(pc), 256'(16'hFFFF));
    cyc(); chk("inc2_wrap", 256'(pc), 256'(16'h0000));
    cyc(); chk("inc3", 256'(pc), 256'(16'h0001));

    // Load beats increment.
    pc_load = 1; pc_target = 16'h0040;
    cyc(); chk("load_over_inc", 256'(pc), 256'(16'h0040));
    // Write-back beats load and raises the conflict flag a cycle later.
    pc_inc = 0; pc_load = 1; pc_target = 16'h0099;
    wr_en = 1; wr_addr = 0; wr_data = 16'h1234;
    cyc();
    idle();
    chk("wb_over_load", 256'(pc), 256'(16'h1234));
    chk("conflict_hi", 256'(pc_conflict), 256'(1));
    cyc();
    chk("conflict_lo", 256'(pc_conflict), 256'(0));

    // Write reg 5 while reading it.
    rd_addr = {4'd0, 4'd0, 4'd5};
    wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rd_same_cycle", 256'(rd_data[15:0]), 256'(16'hBEEF));
`else
    chk("rd_same_cycle", 256'(rd_data[15:0]), 256'(16'h0000));
`endif
    cyc();
    idle();
    chk("rd_next_cycle", 256'(rd_data[15:0]), 256'(16'hBEEF));
    chk("reg5", 256'(reg_of(5)), 256'(16'hBEEF));

    // GP write together with increment: both apply.
    wr_en = 1; wr_addr = 7; wr_data = 16'h0777; pc_inc = 1;
    cyc();
    idle();
    chk("inc_with_wr_pc", 256'(pc), 256'(16'h1235));
    chk("inc_with_wr_r7", 256'(reg_of(7)), 256'(16'h0777));

    // Three independent read ports.
    rd_addr = {4'd5, 4'd5, 4'd0};
    #1;
    chk("rd3_p0", 256'(rd_data[15:0]), 256'(16'h1235));
    chk("rd3_p0_is_pc", 256'(rd_data[15:0]), 256'(pc));
    chk("rd3_p1", 256'(rd_data[31:16]), 256'(16'hBEEF));
    chk("rd3_p2", 256'(rd_data[47:32]), 256'(16'hBEEF));

    // Fill several GP registers and read them back on rotating ports.
    for (int i = 1; i < NR; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = 16'(i * 16'h1111);
      rd_addr = {AW'(i), AW'(i - 1), AW'((i + 1) % NR)};
      cyc();
    end
    idle();
    cyc();
    chk("fill_r3", 256'(reg_of(3)), 256'(16'h3333));
    chk("fill_r15", 256'(reg_of(15)), 256'(16'hFFFF));

    // Reset mid-cycle while a write and an increment are pending.
    wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5; pc_inc = 1;
    #2;
    reset = 1;
    @(posedge clock);
    #1;
    idle();
    #2;
    reset = 0;
    #1;
    chk("rst_mid_pc", 256'(pc), 256'(16'h0100));
    chk("rst_mid_r3", 256'(reg_of(3)), 256'(16'h0000));
    cyc();
    chk("rst_after_pc", 256'(pc), 256'(16'h0100));
    chk("rst_after_r3", 256'(reg_of(3)), 256'(16'h0000));
    chk("rst_after_conflict", 256'(pc_conflict), 256'(0));
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
